// File: rtl/multicycle_control_if.sv
// Control bus of the multicycle MIPS controller: instruction fields and status in,
// datapath selects, enables and debug state out.
interface multicycle_control_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         Op;
    logic [5:0]         Funct;
    logic               Zero;
    logic               mem_ready;
    logic               IorD;
    logic               IRWrite;
    logic               MemWrite;
    logic               RegDst;
    logic               MemtoReg;
    logic               RegWrite;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         PCSrc;
    logic [2:0]         ALUControl;
    logic               PCEn;
    logic               illegal_op;
    logic               retire;
    logic [STATE_W-1:0] state;

    modport slave (
        input  Op, Funct, Zero, mem_ready,
        output IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               ALUSrcB, PCSrc, ALUControl, PCEn, illegal_op, retire, state
    );

    modport master (
        output Op, Funct, Zero, mem_ready,
        input  IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               ALUSrcB, PCSrc, ALUControl, PCEn, illegal_op, retire, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore controller for a multicycle MIPS subset; control word is registered from the next state,
// only mem_ready/Zero/Funct/Op gating is combinational. Memory states hold until mem_ready.
module multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.slave  bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       reg_dst;
        logic       memto_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       branch;
        logic       pc_write;
        logic       fetch;
        logic       decode;
        logic       retire;
    } ctrl_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Unconditional part of each state's control word; mem_ready-gated terms are added at the outputs.
    function automatic ctrl_t moore_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.alu_src_b = 2'b01;
                c.fetch     = 1'b1;
            end
            DECODE: begin
                c.alu_src_b = 2'b11;
                c.decode    = 1'b1;
            end
            MEMADR, ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEMRD:  c.iord = 1'b1;
            MEMWB: begin
                c.memto_reg = 1'b1;
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            ALUWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b01;
                c.pc_src    = 2'b01;
                c.branch    = 1'b1;
                c.retire    = 1'b1;
            end
            ADDIWB: begin
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            JUMP: begin
                c.pc_src   = 2'b10;
                c.pc_write = 1'b1;
                c.retire   = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t     r_state;
    state_t     w_next;
    ctrl_t      r_ctrl;
    logic       w_legal_op;
    logic [2:0] w_alu_ctrl;

    assign w_legal_op = bus.Op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J};

    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:  w_next = bus.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (bus.Op)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_RTYPE:     w_next = EXEC;
                    OP_BEQ:       w_next = BRANCH;
                    OP_ADDI:      w_next = ADDIEX;
                    OP_J:         w_next = JUMP;
                    default:      w_next = FETCH;
                endcase
            end
            MEMADR: w_next = (bus.Op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  w_next = bus.mem_ready ? MEMWB : MEMRD;
            MEMWR:  w_next = bus.mem_ready ? FETCH : MEMWR;
            EXEC:   w_next = ALUWB;
            ADDIEX: w_next = ADDIWB;
            default: w_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
            r_ctrl  <= moore_ctrl(FETCH);
        end else begin
            r_state <= w_next;
            r_ctrl  <= moore_ctrl(w_next);
        end
    end

    always_comb begin
        w_alu_ctrl = 3'b010;
        case (r_ctrl.alu_op)
            2'b01: w_alu_ctrl = 3'b110;
            2'b10: begin
                case (bus.Funct)
                    6'b100000: w_alu_ctrl = 3'b010;
                    6'b100010: w_alu_ctrl = 3'b110;
                    6'b100100: w_alu_ctrl = 3'b000;
                    6'b100101: w_alu_ctrl = 3'b001;
                    6'b101010: w_alu_ctrl = 3'b111;
                    default:   w_alu_ctrl = 3'b010;
                endcase
            end
            default: w_alu_ctrl = 3'b010;
        endcase
    end

    assign bus.IorD       = r_ctrl.iord;
    assign bus.MemWrite   = r_ctrl.mem_write;
    assign bus.RegDst     = r_ctrl.reg_dst;
    assign bus.MemtoReg   = r_ctrl.memto_reg;
    assign bus.RegWrite   = r_ctrl.reg_write;
    assign bus.ALUSrcA    = r_ctrl.alu_src_a;
    assign bus.ALUSrcB    = r_ctrl.alu_src_b;
    assign bus.PCSrc      = r_ctrl.pc_src;
    assign bus.ALUControl = w_alu_ctrl;
    // Reset sits in FETCH, so the fetch strobes need rst_n to stay quiet while it is held.
    assign bus.IRWrite    = rst_n & r_ctrl.fetch & bus.mem_ready;
    assign bus.PCEn       = rst_n & (r_ctrl.pc_write | (r_ctrl.fetch & bus.mem_ready)
                                     | (r_ctrl.branch & bus.Zero));
    assign bus.illegal_op = r_ctrl.decode & ~w_legal_op;
    assign bus.retire     = r_ctrl.retire | (r_ctrl.mem_write & bus.mem_ready);
    assign bus.state      = STATE_W'(r_state);
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one parameter: STATE_W, default 4, state register width (fixed; any other value is unsupported).
REQ-002 The block SHALL have port clk, input, 1, system clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 The block SHALL have port Op, input, 6, instruction opcode (Instr[31:26]).
REQ-005 The block SHALL have port Funct, input, 6, R-type function field (Instr[5:0]).
REQ-006 The block SHALL have port Zero, input, 1, ALU zero flag.
REQ-007 The block SHALL have port mem_ready, input, 1, memory access completes this cycle.
REQ-008 The block SHALL have ports IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite and ALUSrcA, each output, 1, datapath selects and enables.
REQ-009 The block SHALL have ports ALUSrcB, output, 2 and PCSrc, output, 2, datapath muxes.
REQ-010 The block SHALL have port ALUControl, output, 3, ALU operation.
REQ-011 The block SHALL have port PCEn, output, 1, PC register load enable.
REQ-012 The block SHALL have ports illegal_op, output, 1 and retire, output, 1, single-cycle status pulses.
REQ-013 The block SHALL have port state, output, STATE_W, current state for debug.

Function
REQ-014 The block SHALL use Moore control: every output is a function of state only, except PCEn, ALUControl and the mem_ready gating.
REQ-015 State encoding SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-016 Codes 12-15 SHALL transition to FETCH with all outputs 0.
REQ-017 FETCH SHALL go to DECODE when mem_ready=1; otherwise it holds.
REQ-018 DECODE SHALL branch on Op: 100011 or 101011 to MEMADR; 000000 to EXEC; 000100 to BRANCH; 001000 to ADDIEX; 000010 to JUMP.
REQ-019 DECODE with any other Op SHALL go to FETCH and pulse illegal_op for one cycle in DECODE.
REQ-020 MEMADR SHALL go to MEMRD for Op=100011, else to MEMWR.
REQ-021 MEMRD SHALL go to MEMWB on mem_ready=1 (holds otherwise); MEMWR SHALL go to FETCH on mem_ready=1 (holds otherwise).
REQ-022 The transitions MEMWB, ALUWB, ADDIWB, BRANCH and JUMP to FETCH, EXEC to ALUWB, and ADDIEX to ADDIWB SHALL be unconditional.
REQ-023 Outputs not listed for a state SHALL be 0.
REQ-024 FETCH SHALL drive ALUSrcB=01, IRWrite=mem_ready, PCWrite=mem_ready.
REQ-025 DECODE SHALL drive ALUSrcB=11.
REQ-026 MEMADR and ADDIEX SHALL drive ALUSrcA=1, ALUSrcB=10.
REQ-027 MEMRD SHALL drive IorD=1.
REQ-028 MEMWB SHALL drive MemtoReg=1, RegWrite=1.
REQ-029 MEMWR SHALL drive IorD=1, MemWrite=1 (held until mem_ready).
REQ-030 EXEC SHALL drive ALUSrcA=1, ALUOp=10.
REQ-031 ALUWB SHALL drive RegDst=1, RegWrite=1; ADDIWB SHALL drive RegWrite=1.
REQ-032 BRANCH SHALL drive ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1.
REQ-033 JUMP SHALL drive PCSrc=10, PCWrite=1.
REQ-034 PCEn SHALL equal PCWrite OR (Branch AND Zero), combinationally.
REQ-035 ALUControl SHALL be 010 for ALUOp=00 and 110 for ALUOp=01.
REQ-036 For ALUOp=10, ALUControl SHALL map Funct 100000 to 010, 100010 to 110, 100100 to 000, 100101 to 001, 101010 to 111, and any other Funct to 010.
REQ-037 retire SHALL pulse for one cycle on the final cycle of each instruction: MEMWB, MEMWR with mem_ready=1, ALUWB, ADDIWB, BRANCH, JUMP.

Reset
REQ-038 rst_n=0 SHALL immediately force state=FETCH, independent of clk.
REQ-039 While rst_n=0, IRWrite, PCEn, RegWrite, MemWrite, illegal_op and retire SHALL be 0.
REQ-040 Reset asserted mid-instruction SHALL abandon it with no further register or memory write; the first cycle after release is FETCH.

Verification
REQ-041 lw (Op=100011), mem_ready=1 -> states 0,1,2,3,4,0; RegWrite=1, MemtoReg=1 only in state 4; retire there.
REQ-042 beq (Op=000100), Zero=1 -> PCEn=1, PCSrc=01 in BRANCH; with Zero=0 -> PCEn=0 in BRANCH.
REQ-043 R-type, Funct=101010 -> ALUControl=111 in EXEC, then ALUWB with RegDst=1, RegWrite=1.
REQ-044 mem_ready=0 for 3 cycles in FETCH -> state stays 0, IRWrite=PCEn=0; on the 4th cycle mem_ready=1 -> IRWrite=PCEn=1, next state 1.
REQ-045 Op=111111 -> illegal_op=1 for one cycle in DECODE, next state 0, no RegWrite/MemWrite.
REQ-046 sw with mem_ready=0, rst_n dropped mid-MEMWR -> MemWrite falls to 0 asynchronously, state=0 after release.
